keccak_lane_sipo: RTL

- Serial-in, parallel-out lane packer upstream of the Keccak permutation and the lane PISO.
- Accepts 64-bit lanes over a valid/ready handshake and assembles them into a 1600-bit Keccak state.
- Presents the state with a held valid until the consumer accepts it.
- Lane order matches the PISO: the first lane in lands at state[1599:1536], the second at state[1535:1472], and so on, so a PISO→SIPO loopback is bit-exact.

---
 rtl/keccak_lane_sipo.sv | 103 ++++++++++
 1 files changed

// File: rtl/keccak_lane_sipo.sv
// Keccak lane packer: collects RATE_LANES 64-bit lanes, first lane into the top slot, into a
// 1600-bit state and holds it with out_valid until the consumer takes it.
module keccak_lane_sipo #(
  parameter int RATE_LANES = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   in_lane,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [1599:0] state_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    lane_cnt
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [4:0] r_lane_cnt;
  logic       r_out_valid;
  logic       w_accept;
  logic       w_handoff;
  logic       w_last;

  assign w_last    = (r_lane_cnt == LAST_IDX);
  assign lane_cnt  = r_lane_cnt;
  assign out_valid = r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // in_ready decodes the state only, so the handoff edge can never also accept a lane.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_handoff    = 1'b0;
    in_ready     = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_state_next = FULL;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          w_handoff    = 1'b1;
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_cnt  <= 5'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == FULL);
      if (w_accept) begin
        r_lane_cnt <= r_lane_cnt + 5'd1;
      end else if (w_handoff) begin
        r_lane_cnt <= 5'd0;
      end
    end
  end

  // Only rate slots get storage; capacity slots are hard zero.
  for (genvar g = 0; g < 25; g++) begin : g_slot
    if (g < RATE_LANES) begin : g_rate
      logic [63:0] r_slot;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_slot <= 64'd0;
        end else if (w_handoff) begin
          r_slot <= 64'd0;
        end else if (w_accept && (r_lane_cnt == 5'(g))) begin
          r_slot <= in_lane;
        end
      end
      assign state_out[1599-64*g -: 64] = r_slot;
    end else begin : g_cap
      assign state_out[1599-64*g -: 64] = 64'd0;
    end
  end

endmodule
